// File: rtl/mem_access_unit.sv
// Load/store request sequencer in front of the cache + data RAM: buffers requests,
// issues them one at a time, returns results in order. Optional: MEMACC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// ISSUE | memStart pulse, memory fields loaded from FIFO head
// WAIT  | fields held, waiting for memDataReady (or timeout)
// RESP  | response presented until respReady
module mem_access_unit #(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int queueDepth    = 2,
    parameter int timeoutCycles = 255
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqWrite,
    input  logic                reqIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] reqData,
    output logic                respValid,
    input  logic                respReady,
    output logic [ramWidth-1:0] respData,
    output logic                respWrite,
    output logic                respErr,
    output logic                memStart,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIsIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady,
    output logic                busy
);
    localparam int ptrW = $clog2(queueDepth);
    localparam int cntW = ptrW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateType;

    stateType state, nextState;

    logic                fifoWrite    [queueDepth];
    logic                fifoIndirect [queueDepth];
    logic [addrSize-1:0] fifoAddr     [queueDepth];
    logic [ramWidth-1:0] fifoData     [queueDepth];
    logic [ptrW-1:0]     wrPtr, rdPtr;
    logic [cntW-1:0]     count;

    logic push, pop, loadIssue, completeOk, timeoutHit;

    assign reqReady  = (count != cntW'(queueDepth));
    assign push      = reqValid && reqReady;
    assign memStart  = (state == ISSUE);
    assign respValid = (state == RESP);
    assign busy      = (state != IDLE) || (count != '0);

`ifdef MEMACC_TIMEOUT_EN
    logic [15:0] waitCnt;
    logic        respErrQ;
    assign respErr = respErrQ;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            waitCnt <= '0;
        end else if (state == ISSUE) begin
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + 16'd1;
        end
    end
`else
    assign respErr = 1'b0;
`endif

    always_comb begin
        nextState  = state;
        pop        = 1'b0;
        loadIssue  = 1'b0;
        completeOk = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    nextState = ISSUE;
                    loadIssue = 1'b1;
                end
            end
            ISSUE: nextState = WAIT;
            WAIT: begin
                if (memDataReady) begin
                    completeOk = 1'b1;
                    pop        = 1'b1;
                    nextState  = RESP;
                end
`ifdef MEMACC_TIMEOUT_EN
                // limit reached on the timeoutCycles-th WAIT cycle; dataReady wins a tie
                else if (waitCnt == 16'(timeoutCycles - 1)) begin
                    timeoutHit = 1'b1;
                    pop        = 1'b1;
                    nextState  = RESP;
                end
`endif
            end
            RESP: begin
                if (respReady) begin
                    if (count != '0) begin
                        nextState = ISSUE;
                        loadIssue = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // FIFO storage needs no reset; validity is carried by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifoWrite[wrPtr]    <= reqWrite;
            fifoIndirect[wrPtr] <= reqIndirect;
            fifoAddr[wrPtr]     <= reqAddr;
            fifoData[wrPtr]     <= reqData;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            memCntrl      <= 2'b00;
            memAddr       <= '0;
            memDataIn     <= '0;
            memIsIndirect <= 1'b0;
            respData      <= '0;
            respWrite     <= 1'b0;
`ifdef MEMACC_TIMEOUT_EN
            respErrQ      <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end

            if (loadIssue) begin
                memCntrl      <= fifoWrite[rdPtr] ? 2'b10 : 2'b01;
                memAddr       <= fifoAddr[rdPtr];
                memDataIn     <= fifoData[rdPtr];
                memIsIndirect <= fifoIndirect[rdPtr];
            end else if (completeOk || timeoutHit) begin
                memCntrl <= 2'b00;
            end

            if (completeOk) begin
                respData  <= fifoWrite[rdPtr] ? fifoData[rdPtr] : memDataOut;
                respWrite <= fifoWrite[rdPtr];
`ifdef MEMACC_TIMEOUT_EN
                respErrQ  <= 1'b0;
`endif
            end else if (timeoutHit) begin
                respData  <= '0;
                respWrite <= fifoWrite[rdPtr];
`ifdef MEMACC_TIMEOUT_EN
                respErrQ  <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request sequencer directly upstream of the memory module (cache + data RAM). Accepts load/store requests from the processor pipeline over a valid/ready handshake and buffers them in a small FIFO. Issues each one to the memory module as a one-cycle `start` pulse with stable `cntrl`/`addr`/`dataIn`, then waits for `dataReady`. Returns the result to the pipeline over a second valid/ready handshake, strictly in order and one transaction at a time.

## Interface
- `ramWidth`, 8, data width; equals the memory module's `ramWidth`.
- `addrSize`, 8, address width; equals the memory module's `addrSize`.
- `queueDepth`, 2, request FIFO depth; power of two, ≥2.
- `timeoutCycles`, 255, WAIT-state cycle limit; used only with `MEMACC_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  FIFO not full; `!full`, combinational from registered count.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqIndirect`  in  1  indirect-addressing flag, forwarded to memory.
- `reqAddr`  in  addrSize  request address.
- `reqData`  in  ramWidth  store data.
- `respValid`  out  1  response present.
- `respReady`  in  1  consumer accepts response.
- `respData`  out  ramWidth  load data; for stores, the data written.
- `respWrite`  out  1  echo of the request's `reqWrite`.
- `respErr`  out  1  timeout flag; constant 0 without `MEMACC_TIMEOUT_EN`.
- `memStart`  out  1  to memory `start`.
- `memCntrl`  out  2  to memory `cntrl`: 00 idle, 01 read, 10 write; 11 is never driven.
- `memAddr`  out  addrSize  to memory `addr`.
- `memDataIn`  out  ramWidth  to memory `dataIn`.
- `memIsIndirect`  out  1  to memory `isIndirect`.
- `memDataOut`  in  ramWidth  from memory `dataOut`.
- `memDataReady`  in  1  from memory `dataReady`.
- `busy`  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- FIFO entry holds {write, indirect, addr, data}.
  - Push on `reqValid && reqReady`.
  - Pop on transaction completion.
  - A push while full is impossible: `reqReady` derives from the registered count, so no push happens in a full cycle even if a pop occurs.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo `queueDepth`.
- FSM states:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: `memStart`=1 for exactly this cycle, fields driven from the FIFO head. → WAIT.
  - WAIT: outputs held stable. `memDataReady`=1 → capture `memDataOut` (loads) or head data (stores) into `respData`, latch `respWrite`, pop, → RESP.
  - RESP: `respValid`=1 until `respReady`. On handshake → ISSUE if FIFO non-empty, else IDLE.
- `memCntrl`/`memAddr`/`memDataIn`/`memIsIndirect` are registered and valid from ISSUE through WAIT. `memCntrl`=00 in IDLE/RESP; address and data hold their last value there.
- `memDataReady` is sampled only in WAIT; it is ignored in ISSUE, IDLE and RESP.
- Response registers hold stable while `respValid`=1 and `respReady`=0.
- `clr` asserted at any time (including mid-WAIT): FIFO emptied, FSM → IDLE, in-flight transaction dropped with no response.

## Timing
- Reset values: `memStart`, `memCntrl`, `memAddr`, `memDataIn`, `memIsIndirect`, `respValid`, `respData`, `respWrite`, `respErr`, `busy` = 0. `reqReady` = 1.
- Request accepted in cycle 0 with the FIFO empty and FSM in IDLE:
  - cycle 1: IDLE (FIFO non-empty visible).
  - cycle 2: ISSUE, `memStart`=1.
  - cycle 3: WAIT begins.
- `memDataReady` high in cycle k (k ≥ 3) → `respValid`=1 in cycle k+1.
- Back-to-back: response handshake in cycle r with FIFO non-empty → ISSUE in cycle r+1 (no IDLE cycle).
- Throughput: at most one transaction in flight.

## Configuration
- `MEMACC_TIMEOUT_EN` defined:
  - 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `timeoutCycles` with `memDataReady`=0: pop, `respData`=0, `respErr`=1, → RESP, `memCntrl`→00.
  - `memDataReady` in the same cycle as the limit wins: normal completion, `respErr`=0.
- Not defined: no counter; WAIT persists indefinitely; `respErr` tied 0.

## Test plan
- Reset, then load addr 0x10, memory returns 0xA5 with `memDataReady` in cycle 4 → `memStart` pulse only in cycle 2, `memCntrl`=01, `respValid` cycle 5, `respData`=0xA5, `respWrite`=0.
- Store 0x3C to 0x22 with `reqIndirect`=1 → `memCntrl`=10, `memAddr`=0x22, `memDataIn`=0x3C, `memIsIndirect`=1 stable through WAIT; response `respData`=0x3C, `respWrite`=1.
- Three requests pushed back-to-back, `queueDepth`=2 → `reqReady`=0 after the second push; third accepted after the first pop; responses in order; ISSUE immediately follows each RESP handshake.
- `respReady` held 0 for 5 cycles during RESP → `respValid`/`respData` stable, no new `memStart`.
- `clr` pulsed mid-WAIT → all outputs at reset values next cycle, `reqReady`=1, no response emitted.
- With `MEMACC_TIMEOUT_EN`, `timeoutCycles`=4, `memDataReady` never asserted → RESP with `respErr`=1, `respData`=0; without the macro → still in WAIT after 300 cycles.
